// File: rtl/reg_file_sb.sv
// Parametrised register file with two writeback ports, write-through bypass and
// a per-register busy scoreboard used by decode to stall hazarded reads.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     SYS_reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     lw_en,
  input  logic [ADDR_W-1:0]        lw_addr,
  input  logic [DATA_W-1:0]        lw_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     err_collide,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic wr_ok_s, lw_ok_s, issue_ok_s, collide_s, set_new_s, clr_old_s;

  // Qualify write/issue requests: writes and busy marks to a hardwired r0 are dropped.
  always_comb begin
    wr_ok_s    = wr_en && !(ZR_EN && (wr_addr == '0));
    lw_ok_s    = lw_en && !(ZR_EN && (lw_addr == '0));
    issue_ok_s = issue_en && !(ZR_EN && (issue_addr == '0));
    collide_s  = wr_ok_s && lw_ok_s && (wr_addr == lw_addr);
  end

  // Scoreboard next state; the set term is OR-ed last so a new producer wins over a clear.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i] = (issue_ok_s && (issue_addr == ADDR_W'(i))) ||
                  (busy_q[i] && !(lw_en && (lw_addr == ADDR_W'(i))));
    end
    set_new_s = issue_ok_s && !busy_q[issue_addr];
    clr_old_s = lw_en && busy_q[lw_addr] && !(issue_ok_s && (issue_addr == lw_addr));
    cnt_d     = cnt_q + {{ADDR_W{1'b0}}, set_new_s} - {{ADDR_W{1'b0}}, clr_old_s};
    err_d     = err_q | collide_s;
  end

  // Scoreboard, busy population and sticky collision flag.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Register array; on a same-address collision the main port's data is kept.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_ok_s) begin
        mem_q[wr_addr] <= wr_data;
      end
      if (lw_ok_s && !collide_s) begin
        mem_q[lw_addr] <= lw_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rdat_s;

    assign ra_s = rd_addr[g*ADDR_W +: ADDR_W];

    // Read mux with write-through bypass, main port taking priority over long-latency.
    always_comb begin
      if (ZR_EN && (ra_s == '0)) begin
        rdat_s = '0;
      end else if (wr_en && (wr_addr == ra_s)) begin
        rdat_s = wr_data;
      end else if (lw_en && (lw_addr == ra_s)) begin
        rdat_s = lw_data;
      end else begin
        rdat_s = mem_q[ra_s];
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rdat_s;
    assign rd_busy[g] = busy_q[ra_s] & ~(lw_en & (lw_addr == ra_s));
  end

  assign busy_cnt    = cnt_q;
  assign err_collide = err_q;
  assign dbg_data    = mem_q[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default configuration plus a narrow
// 16-bit / 8-entry / 3-read-port instance without a zero register.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic SYS_reset_n;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en, a_lw_en, a_issue_en, a_err;
  logic [4:0]  a_wr_addr, a_lw_addr, a_issue_addr, a_dbg_addr;
  logic [31:0] a_wr_data, a_lw_data, a_dbg_data;
  logic [5:0]  a_busy_cnt;

  logic [8:0]  b_rd_addr;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_wr_en, b_lw_en, b_issue_en, b_err;
  logic [2:0]  b_wr_addr, b_lw_addr, b_issue_addr, b_dbg_addr;
  logic [15:0] b_wr_data, b_lw_data, b_dbg_data;
  logic [3:0]  b_busy_cnt;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .SYS_reset_n(SYS_reset_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .lw_en(a_lw_en), .lw_addr(a_lw_addr), .lw_data(a_lw_data),
    .issue_en(a_issue_en), .issue_addr(a_issue_addr),
    .busy_cnt(a_busy_cnt), .err_collide(a_err),
    .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) u_b (
    .clk(clk), .SYS_reset_n(SYS_reset_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .lw_en(b_lw_en), .lw_addr(b_lw_addr), .lw_data(b_lw_data),
    .issue_en(b_issue_en), .issue_addr(b_issue_addr),
    .busy_cnt(b_busy_cnt), .err_collide(b_err),
    .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
  );

  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic expect_v(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_v(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    a_wr_en = 1'b0; a_lw_en = 1'b0; a_issue_en = 1'b0;
    b_wr_en = 1'b0; b_lw_en = 1'b0; b_issue_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    SYS_reset_n = 1'b0;
    idle();
    a_rd_addr = 10'd0; a_wr_addr = 5'd0; a_wr_data = 32'd0; a_lw_addr = 5'd0;
    a_lw_data = 32'd0; a_issue_addr = 5'd0; a_dbg_addr = 5'd5;
    b_rd_addr = 9'd0; b_wr_addr = 3'd0; b_wr_data = 16'd0; b_lw_addr = 3'd0;
    b_lw_data = 16'd0; b_issue_addr = 3'd0; b_dbg_addr = 3'd0;

    repeat (2) @(posedge clk);
    #1;
    expect_v("rst_busy_cnt", 64'd0); check_v(a_busy_cnt);
    expect_v("rst_err", 64'd0);      check_v(a_err);
    expect_v("rst_dbg", 64'd0);      check_v(a_dbg_data);
    SYS_reset_n = 1'b1;

    // first edge after reset release behaves normally
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    a_issue_en = 1'b1; a_issue_addr = 5'd6;
    expect_v("first_edge_dbg", 64'hDEADBEEF);
    expect_v("first_edge_cnt", 64'd1);
    step(); idle();
    check_v(a_dbg_data);
    check_v(a_busy_cnt);

    a_rd_addr = {5'd0, 5'd5};
    #3 SYS_reset_n = 1'b0;
    #1;
    expect_v("midrst_rd", 64'd0);  check_v(a_rd_data[31:0]);
    expect_v("midrst_cnt", 64'd0); check_v(a_busy_cnt);
    expect_v("midrst_err", 64'd0); check_v(a_err);
    #1 SYS_reset_n = 1'b1;

    a_rd_addr = {5'd5, 5'd7}; a_dbg_addr = 5'd7;
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h1234;
    expect_v("bypass_rd", 64'h1234);
    expect_v("bypass_dbg_pre", 64'd0);
    #1;
    check_v(a_rd_data[31:0]);
    check_v(a_dbg_data);
    expect_v("bypass_dbg_post", 64'h1234);
    step(); idle();
    check_v(a_dbg_data);

    a_rd_addr = {5'd5, 5'd0};
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFF;
    expect_v("zero_rd_bypass", 64'd0);
    #1 check_v(a_rd_data[31:0]);
    step(); idle();
    a_dbg_addr = 5'd0;
    expect_v("zero_dbg", 64'd0);
    #1 check_v(a_dbg_data);

    a_issue_en = 1'b1; a_issue_addr = 5'd3;
    step(); idle();
    a_rd_addr = {5'd3, 5'd0};
    expect_v("issue_busy", 64'b10);
    expect_v("issue_cnt", 64'd1);
    #1;
    check_v(a_rd_busy);
    check_v(a_busy_cnt);
    a_lw_en = 1'b1; a_lw_addr = 5'd3; a_lw_data = 32'hAA;
    expect_v("lw_busy_bypass", 64'b00);
    expect_v("lw_data_bypass", 64'hAA);
    #1;
    check_v(a_rd_busy);
    check_v(a_rd_data[63:32]);
    step(); idle();
    expect_v("lw_cnt_after", 64'd0);
    #1 check_v(a_busy_cnt);

    a_issue_en = 1'b1; a_issue_addr = 5'd4;
    step(); idle();
    expect_v("r4_cnt", 64'd1);
    #1 check_v(a_busy_cnt);
    a_rd_addr = {5'd3, 5'd4};
    a_issue_en = 1'b1; a_issue_addr = 5'd4;
    a_lw_en = 1'b1; a_lw_addr = 5'd4; a_lw_data = 32'h44;
    expect_v("setclr_same_busy_now", 64'b00);
    #1 check_v(a_rd_busy);
    step(); idle();
    expect_v("setclr_same_cnt", 64'd1);
    expect_v("setclr_same_busy", 64'b01);
    #1;
    check_v(a_busy_cnt);
    check_v(a_rd_busy);

    a_issue_en = 1'b1; a_issue_addr = 5'd9;
    step(); idle();
    expect_v("r9_cnt", 64'd2);
    #1 check_v(a_busy_cnt);
    a_issue_en = 1'b1; a_issue_addr = 5'd8;
    a_lw_en = 1'b1; a_lw_addr = 5'd9; a_lw_data = 32'h99;
    step(); idle();
    a_rd_addr = {5'd9, 5'd8};
    expect_v("setclr_diff_cnt", 64'd2);
    expect_v("setclr_diff_busy", 64'b01);
    expect_v("setclr_diff_data", 64'h99);
    #1;
    check_v(a_busy_cnt);
    check_v(a_rd_busy);
    check_v(a_rd_data[63:32]);

    a_issue_en = 1'b1; a_issue_addr = 5'd0;
    step(); idle();
    a_rd_addr = {5'd9, 5'd0};
    expect_v("r0_issue_cnt", 64'd2);
    expect_v("r0_issue_busy", 64'b00);
    #1;
    check_v(a_busy_cnt);
    check_v(a_rd_busy);

    a_rd_addr = {5'd9, 5'd10}; a_dbg_addr = 5'd10;
    a_wr_en = 1'b1; a_wr_addr = 5'd10; a_wr_data = 32'h1;
    a_lw_en = 1'b1; a_lw_addr = 5'd10; a_lw_data = 32'h2;
    expect_v("collide_rd_prio", 64'h1);
    #1 check_v(a_rd_data[31:0]);
    step(); idle();
    expect_v("collide_dbg", 64'h1);
    expect_v("collide_err", 64'd1);
    #1;
    check_v(a_dbg_data);
    check_v(a_err);
    repeat (3) step();
    expect_v("collide_sticky", 64'd1);
    check_v(a_err);
    SYS_reset_n = 1'b0;
    expect_v("collide_rst_err", 64'd0);
    expect_v("collide_rst_cnt", 64'd0);
    #1;
    check_v(a_err);
    check_v(a_busy_cnt);
    #1 SYS_reset_n = 1'b1;

    b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = 16'hBEEF;
    step(); idle();
    b_rd_addr = {3'd0, 3'd0, 3'd0};
    expect_v("b_r0_writable", 64'hBEEF);
    #1 check_v(b_rd_data[15:0]);
    b_wr_en = 1'b1; b_wr_addr = 3'd1; b_wr_data = 16'h1111;
    b_lw_en = 1'b1; b_lw_addr = 3'd2; b_lw_data = 16'h2222;
    step(); idle();
    b_rd_addr = {3'd1, 3'd0, 3'd2};
    expect_v("b_port0", 64'h2222);
    expect_v("b_port1", 64'hBEEF);
    expect_v("b_port2", 64'h1111);
    expect_v("b_no_err", 64'd0);
    #1;
    check_v(b_rd_data[15:0]);
    check_v(b_rd_data[31:16]);
    check_v(b_rd_data[47:32]);
    check_v(b_err);

    for (int i = 0; i < 8; i++) begin
      b_issue_en = 1'b1; b_issue_addr = 3'(i);
      step();
    end
    idle();
    expect_v("b_cnt_full", 64'd8);
    #1 check_v(b_busy_cnt);
    b_issue_en = 1'b1; b_issue_addr = 3'd3;
    step(); idle();
    expect_v("b_cnt_nowrap", 64'd8);
    expect_v("b_busy_all", 64'b111);
    #1;
    check_v(b_busy_cnt);
    check_v(b_rd_busy);
    b_lw_en = 1'b1; b_lw_addr = 3'd5; b_lw_data = 16'h5555;
    step(); idle();
    expect_v("b_cnt_dec", 64'd7);
    #1 check_v(b_busy_cnt);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's register file.
- Generalises data width, depth and read-port count.
- Adds a second writeback port for long-latency results (loads and mult/div), an optional hardwired zero register, and write-through bypass on both write ports.
- Adds a per-register busy scoreboard, with a busy-count counter, that the decode stage uses to stall hazarded reads.
- Sits between decode (read/issue) and the two writeback paths.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- SYS_reset_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational, bypassed.
- rd_busy  out  NUM_RD  per-port hazard flag for rd_addr[i].
- wr_en  in  1  main (ALU) writeback enable.
- wr_addr  in  ADDR_W  main writeback address.
- wr_data  in  DATA_W  main writeback data.
- lw_en  in  1  long-latency writeback enable; also clears busy.
- lw_addr  in  ADDR_W  long-latency writeback address.
- lw_data  in  DATA_W  long-latency writeback data.
- issue_en  in  1  marks issue_addr busy (long-latency op issued).
- issue_addr  in  ADDR_W  destination of the issued op.
- busy_cnt  out  ADDR_W+1  number of currently busy registers.
- err_collide  out  1  sticky: same-address dual write seen.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  array contents at dbg_addr; no bypass.

Behaviour:
- Reset (SYS_reset_n=0, asynchronous):
  - all registers = 0; busy[] = 0; busy_cnt = 0; err_collide = 0.
  - Holds while low. The first edge after deassertion behaves normally.
  - Reset mid-operation discards all in-flight busy marks.
- Writes, rising edge:
  - wr_en writes wr_data to wr_addr.
  - lw_en writes lw_data to lw_addr.
  - Both enabled, different addresses: both written.
  - Both enabled, same address: wr_data is stored, err_collide set (sticky until reset).
  - ZERO_REG=1 and address 0: write dropped, no error.
- Read, port i, combinational, priority order:
  1. ZERO_REG && rd_addr==0 -> 0.
  2. wr_en && wr_addr==rd_addr -> wr_data.
  3. lw_en && lw_addr==rd_addr -> lw_data.
  4. otherwise array[rd_addr].
- Scoreboard, one busy bit per register, rising edge:
  - issue_en sets busy[issue_addr].
  - lw_en clears busy[lw_addr].
  - Same address in the same cycle: set wins, i.e. busy stays 1 (a new producer is issued).
  - ZERO_REG=1 and address 0: never set.
  - wr_en does not affect busy.
  - Setting an already-busy bit is a no-op.
- rd_busy[i] = busy[rd_addr[i]] & ~(lw_en & lw_addr==rd_addr[i]). The same-cycle clear bypasses into the hazard flag, so no extra stall.
- busy_cnt tracks the population of busy[] and updates on the same edge as busy[]:
  - +1 on a 0->1 transition.
  - -1 on a 1->0 transition.
  - net 0 when one bit sets and another clears in the same cycle.
  - Range 0..2**ADDR_W; never wraps.
- dbg_data = array[dbg_addr], raw; shows the write only after the edge.

Test Plan:
- Reset then read: write 0xDEADBEEF to r5, pulse SYS_reset_n low mid-cycle -> rd_data for r5 reads 0 immediately, busy_cnt=0, err_collide=0.
- Bypass: wr_en with r7=0x1234 while rd_addr[0]=7 -> rd_data port0=0x1234 the same cycle; dbg_data shows 0x1234 only after the edge. Writing r0 with 0xFFFF -> r0 reads 0.
- Scoreboard: issue r3 -> next cycle rd_busy=1 and busy_cnt=1. lw_en r3=0xAA -> same cycle rd_busy=0 and rd_data=0xAA; next cycle busy_cnt=0.
- Simultaneous set/clear:
  - issue r4 and lw r4 in the same cycle -> r4 stays busy, busy_cnt unchanged.
  - issue r8 and lw r9 with r9 busy -> busy_cnt unchanged.
- Collision: wr_en and lw_en both to r10, data 0x1 and 0x2 -> r10=0x1, err_collide=1 and stays 1 until reset.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0 -> r0 writable. Issue all 8 registers -> busy_cnt=8 with no wrap; all three read ports independent.
